// File: rtl/gen_rf_pkg.sv
// gen_rf_pkg
// Shared definitions for the general-purpose register file.
// Holds the fun_sel operation encodings and the 2-bit operation type
// used by gen_reg_file and gen_rf_cell.
//
// Optional feature macro: GEN_RF_SAT_EN (consumed by gen_rf_cell).
package gen_rf_pkg;

    typedef logic [1:0] fun_t;

    localparam fun_t FUN_CLR = 2'b00;
    localparam fun_t FUN_LD  = 2'b01;
    localparam fun_t FUN_DEC = 2'b10;
    localparam fun_t FUN_INC = 2'b11;

endpackage

// File: rtl/gen_rf_cell.sv
// gen_rf_cell
// One register of the register file together with its sticky
// wrap/saturation flag.
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset (clears value and flag)
//   sel     in   1      apply fun to this register in this cycle
//   fun     in   2      00 clear, 01 load, 10 decrement, 11 increment
//   i_data  in   WIDTH  load data
//   value   out  WIDTH  current register content
//   flag    out  1      sticky wrap (or saturation) flag
//
// Build option: define GEN_RF_SAT_EN to make increment/decrement saturate
// at all-ones/zero instead of wrapping modulo 2^WIDTH. The flag is raised
// on the boundary event in both builds.
module gen_rf_cell
    import gen_rf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [1:0]       fun,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] value,
    output logic             flag
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic at_max;
    logic at_min;

    // Boundary detection: incrementing all-ones or decrementing zero is the
    // wrap (or saturation) event that raises the flag.
    assign at_max = &value;
    assign at_min = ~|value;

    // Register and flag update. Reset wins over any selected operation.
    // Clear and load restart the flag; inc/dec only ever set it, so a flag
    // stays raised across later non-wrapping counts until cleared or loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            flag  <= 1'b0;
        end else if (sel) begin
            case (fun)
                FUN_CLR: begin
                    value <= '0;
                    flag  <= 1'b0;
                end
                FUN_LD: begin
                    value <= i_data;
                    flag  <= 1'b0;
                end
                FUN_DEC: begin
                    if (at_min) begin
                        flag <= 1'b1;
                    end
`ifdef GEN_RF_SAT_EN
                    if (!at_min) begin
                        value <= value - ONE;
                    end
`else
                    value <= value - ONE;
`endif
                end
                FUN_INC: begin
                    if (at_max) begin
                        flag <= 1'b1;
                    end
`ifdef GEN_RF_SAT_EN
                    if (!at_max) begin
                        value <= value + ONE;
                    end
`else
                    value <= value + ONE;
`endif
                end
                default: begin
                    value <= value;
                    flag  <= flag;
                end
            endcase
        end
    end

endmodule

// File: rtl/gen_reg_file.sv
// gen_reg_file
// Parametrised general-purpose register file of the ALU datapath:
// NREG registers of WIDTH bits, each independently cleared, loaded,
// decremented or incremented when its reg_sel bit is set. Two registered
// read ports return the content a register held before the current edge.
//
// Ports:
//   clk         in   1      rising-edge clock
//   rst         in   1      synchronous active-high reset
//   i_data      in   WIDTH  load data (from MuxA)
//   fun_sel     in   2      00 clear, 01 load, 10 decrement, 11 increment
//   reg_sel     in   NREG   bit k applies fun_sel to register k
//   o1_sel      in   SELW   read port 1 register index
//   o2_sel      in   SELW   read port 2 register index
//   o1          out  WIDTH  registered read port 1
//   o2          out  WIDTH  registered read port 2
//   wrap_flags  out  NREG   sticky per-register wrap/saturation flags
//   any_wrap    out  1      OR of wrap_flags
//
// Build option: GEN_RF_SAT_EN selects saturating inc/dec (see gen_rf_cell).
module gen_reg_file
    import gen_rf_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREG  = 8,
    parameter int SELW  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic [1:0]       fun_sel,
    input  logic [NREG-1:0]  reg_sel,
    input  logic [SELW-1:0]  o1_sel,
    input  logic [SELW-1:0]  o2_sel,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [NREG-1:0]  wrap_flags,
    output logic             any_wrap
);

    localparam int NSLOT = 2 ** SELW;

    logic [WIDTH-1:0] regs     [NREG];
    logic [WIDTH-1:0] read_tbl [NSLOT];

    genvar k;

    // One cell per register; every cell sees the same operation and data,
    // and its own select bit decides whether it acts this edge.
    generate
        for (k = 0; k < NREG; k++) begin : g_cell
            gen_rf_cell #(
                .WIDTH (WIDTH)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .sel    (reg_sel[k]),
                .fun    (fun_sel),
                .i_data (i_data),
                .value  (regs[k]),
                .flag   (wrap_flags[k])
            );
        end
    endgenerate

    // The read table covers every encodable select value so the muxes never
    // index past the register array; indices beyond NREG read as zero.
    generate
        for (k = 0; k < NSLOT; k++) begin : g_tbl
            if (k < NREG) begin : g_real
                assign read_tbl[k] = regs[k];
            end else begin : g_pad
                assign read_tbl[k] = '0;
            end
        end
    endgenerate

    // Output registers sample the register contents before this edge's
    // update, giving a one-edge read latency after any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            o1 <= '0;
            o2 <= '0;
        end else begin
            o1 <= read_tbl[o1_sel];
            o2 <= read_tbl[o2_sel];
        end
    end

    assign any_wrap = |wrap_flags;

endmodule

// File: tb/tb_gen_reg_file.sv
// tb_gen_reg_file
// Self-checking bench for gen_reg_file. Main instance uses the default
// WIDTH=8/NREG=8; a second instance uses WIDTH=16/NREG=6 to exercise
// out-of-range read selects and a wider datapath.
// Honours GEN_RF_SAT_EN for its expected values.
module tb_gen_reg_file;

    localparam int W = 8;
    localparam int N = 8;

`ifdef GEN_RF_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [1:0] F_CLR = 2'b00;
    localparam logic [1:0] F_LD  = 2'b01;
    localparam logic [1:0] F_DEC = 2'b10;
    localparam logic [1:0] F_INC = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [W-1:0] i_data;
    logic [1:0]   fun_sel;
    logic [N-1:0] reg_sel;
    logic [2:0]   o1_sel;
    logic [2:0]   o2_sel;
    logic [W-1:0] o1;
    logic [W-1:0] o2;
    logic [N-1:0] wrap_flags;
    logic         any_wrap;

    logic         rst16;
    logic [15:0]  d16;
    logic [1:0]   f16;
    logic [5:0]   s16;
    logic [2:0]   a16;
    logic [2:0]   b16;
    logic [15:0]  q1_16;
    logic [15:0]  q2_16;
    logic [5:0]   flags16;
    logic         any16;

    gen_reg_file #(.WIDTH(W), .NREG(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_data     (i_data),
        .fun_sel    (fun_sel),
        .reg_sel    (reg_sel),
        .o1_sel     (o1_sel),
        .o2_sel     (o2_sel),
        .o1         (o1),
        .o2         (o2),
        .wrap_flags (wrap_flags),
        .any_wrap   (any_wrap)
    );

    gen_reg_file #(.WIDTH(16), .NREG(6)) dut16 (
        .clk        (clk),
        .rst        (rst16),
        .i_data     (d16),
        .fun_sel    (f16),
        .reg_sel    (s16),
        .o1_sel     (a16),
        .o2_sel     (b16),
        .o1         (q1_16),
        .o2         (q2_16),
        .wrap_flags (flags16),
        .any_wrap   (any16)
    );

    typedef struct packed {
        logic [1:0]   fun;
        logic [N-1:0] sel;
        logic [W-1:0] data;
        logic [2:0]   s1;
        logic [2:0]   s2;
        logic [W-1:0] e1;
        logic [W-1:0] e2;
        logic [N-1:0] ef;
    } vec_t;

    typedef struct {
        logic [W-1:0] o1;
        logic [W-1:0] o2;
        logic [N-1:0] flags;
        logic         anyw;
        int           step;
    } exp_t;

    vec_t vecs [18];
    exp_t sbq [$];

    logic [W-1:0] mreg [N];
    logic [N-1:0] mflag;

    int total = 0;
    int bad   = 0;
    int stepNo = 0;

    // Single comparison point: every check in the bench goes through here.
    task automatic checkValue(input string name, input int step,
                              input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    // Reference behaviour of the default-size register file for one edge.
    task automatic modelStep(input logic r, input logic [1:0] f,
                             input logic [N-1:0] s, input logic [W-1:0] d);
        for (int k = 0; k < N; k++) begin
            if (r) begin
                mreg[k]  = '0;
                mflag[k] = 1'b0;
            end else if (s[k]) begin
                case (f)
                    F_CLR: begin mreg[k] = '0; mflag[k] = 1'b0; end
                    F_LD:  begin mreg[k] = d;  mflag[k] = 1'b0; end
                    F_DEC: begin
                        if (mreg[k] == 8'h00) begin
                            mflag[k] = 1'b1;
                            mreg[k]  = SAT ? 8'h00 : 8'hFF;
                        end else begin
                            mreg[k] = mreg[k] - 8'h01;
                        end
                    end
                    default: begin
                        if (mreg[k] == 8'hFF) begin
                            mflag[k] = 1'b1;
                            mreg[k]  = SAT ? 8'hFF : 8'h00;
                        end else begin
                            mreg[k] = mreg[k] + 8'h01;
                        end
                    end
                endcase
            end
        end
    endtask

    // Pop the oldest expectation and compare it against the DUT outputs.
    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            checkValue("scoreboard empty", stepNo, 16'd1, 16'd0);
        end else begin
            e = sbq.pop_front();
            checkValue("o1", e.step, {8'h00, o1}, {8'h00, e.o1});
            checkValue("o2", e.step, {8'h00, o2}, {8'h00, e.o2});
            checkValue("wrap_flags", e.step, {8'h00, wrap_flags}, {8'h00, e.flags});
            checkValue("any_wrap", e.step, {15'd0, any_wrap}, {15'd0, e.anyw});
        end
    endtask

    // Drive one cycle of stimulus, push its expectation, clock, then check.
    // With fromTable set the expectation comes from the vector record,
    // otherwise from the reference model.
    task automatic applyStimulus(input logic r, input logic [1:0] f,
                                 input logic [N-1:0] s, input logic [W-1:0] d,
                                 input logic [2:0] a, input logic [2:0] b,
                                 input bit fromTable, input logic [W-1:0] e1,
                                 input logic [W-1:0] e2, input logic [N-1:0] ef);
        exp_t e;
        rst     = r;
        fun_sel = f;
        reg_sel = s;
        i_data  = d;
        o1_sel  = a;
        o2_sel  = b;
        e.step  = stepNo;
        e.o1    = r ? 8'h00 : mreg[a];
        e.o2    = r ? 8'h00 : mreg[b];
        modelStep(r, f, s, d);
        e.flags = mflag;
        if (fromTable) begin
            e.o1    = e1;
            e.o2    = e2;
            e.flags = ef;
        end
        e.anyw = |e.flags;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
        stepNo++;
    endtask

    // One cycle on the wide instance; checks are made by the caller.
    task automatic apply16(input logic r, input logic [1:0] f, input logic [5:0] s,
                           input logic [15:0] d, input logic [2:0] a, input logic [2:0] b);
        rst16 = r;
        f16   = f;
        s16   = s;
        d16   = d;
        a16   = a;
        b16   = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] rd;
        logic [1:0]   rf;

        vecs[0]  = '{F_LD,  8'h09, 8'h5A, 3'd0, 3'd3, 8'h00, 8'h00, 8'h00};
        vecs[1]  = '{F_INC, 8'h00, 8'h00, 3'd0, 3'd3, 8'h5A, 8'h5A, 8'h00};
        vecs[2]  = '{F_CLR, 8'h00, 8'h00, 3'd1, 3'd2, 8'h00, 8'h00, 8'h00};
        vecs[3]  = '{F_LD,  8'h04, 8'h10, 3'd2, 3'd7, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{F_INC, 8'h04, 8'h00, 3'd2, 3'd2, 8'h10, 8'h10, 8'h00};
        vecs[5]  = '{F_LD,  8'h00, 8'h00, 3'd2, 3'd2, 8'h11, 8'h11, 8'h00};
        vecs[6]  = '{F_LD,  8'h02, 8'hFF, 3'd1, 3'd0, 8'h00, 8'h5A, 8'h00};
        vecs[7]  = '{F_INC, 8'h02, 8'h00, 3'd1, 3'd3, 8'hFF, 8'h5A, 8'h02};
        vecs[8]  = '{F_INC, 8'h02, 8'h00, 3'd1, 3'd3, SAT ? 8'hFF : 8'h00, 8'h5A, 8'h02};
        vecs[9]  = '{F_DEC, 8'h00, 8'h00, 3'd1, 3'd3, SAT ? 8'hFF : 8'h01, 8'h5A, 8'h02};
        vecs[10] = '{F_LD,  8'h02, 8'h00, 3'd1, 3'd3, SAT ? 8'hFF : 8'h01, 8'h5A, 8'h00};
        vecs[11] = '{F_DEC, 8'h10, 8'h00, 3'd4, 3'd1, 8'h00, 8'h00, 8'h10};
        vecs[12] = '{F_LD,  8'h20, 8'hFF, 3'd4, 3'd5, SAT ? 8'h00 : 8'hFF, 8'h00, 8'h10};
        vecs[13] = '{F_INC, 8'h20, 8'h00, 3'd5, 3'd4, 8'hFF, SAT ? 8'h00 : 8'hFF, 8'h30};
        vecs[14] = '{F_CLR, 8'h00, 8'h00, 3'd5, 3'd4, SAT ? 8'hFF : 8'h00, SAT ? 8'h00 : 8'hFF, 8'h30};
        vecs[15] = '{F_CLR, 8'h30, 8'h00, 3'd0, 3'd3, 8'h5A, 8'h5A, 8'h00};
        vecs[16] = '{F_INC, 8'h0D, 8'h00, 3'd0, 3'd2, 8'h5A, 8'h11, 8'h00};
        vecs[17] = '{F_CLR, 8'h00, 8'h00, 3'd3, 3'd2, 8'h5B, 8'h12, 8'h00};

        for (int k = 0; k < N; k++) mreg[k] = '0;
        mflag = '0;

        rst = 1'b1; fun_sel = F_CLR; reg_sel = '0; i_data = '0; o1_sel = '0; o2_sel = '0;
        rst16 = 1'b1; f16 = F_CLR; s16 = '0; d16 = '0; a16 = '0; b16 = '0;
        @(posedge clk);
        #1;

        $display("[TB] reset overriding a load of all registers");
        applyStimulus(1'b1, F_LD, 8'hFF, 8'hAA, 3'd0, 3'd1, 1'b0, '0, '0, '0);
        for (int p = 0; p < N; p += 2) begin
            applyStimulus(1'b0, F_LD, 8'h00, 8'hAA, 3'(p), 3'(p + 1), 1'b0, '0, '0, '0);
        end

        $display("[TB] directed vector table");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, vecs[i].fun, vecs[i].sel, vecs[i].data,
                          vecs[i].s1, vecs[i].s2, 1'b1, vecs[i].e1, vecs[i].e2, vecs[i].ef);
        end

        $display("[TB] reset in the middle of an increment run");
        applyStimulus(1'b0, F_LD,  8'h40, 8'hFE, 3'd6, 3'd0, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, F_INC, 8'h40, 8'h00, 3'd6, 3'd0, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, F_INC, 8'h40, 8'h00, 3'd6, 3'd6, 1'b0, '0, '0, '0);
        applyStimulus(1'b1, F_INC, 8'h40, 8'h00, 3'd6, 3'd6, 1'b0, '0, '0, '0);
        applyStimulus(1'b0, F_CLR, 8'h00, 8'h00, 3'd6, 3'd0, 1'b0, '0, '0, '0);

        $display("[TB] random operations against the model");
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       rd = 8'h00;
                1:       rd = 8'hFF;
                default: rd = 8'($urandom);
            endcase
            rf = 2'($urandom);
            applyStimulus(($urandom_range(0, 40) == 0), rf, 8'($urandom), rd,
                          3'($urandom), 3'($urandom), 1'b0, '0, '0, '0);
        end

        $display("[TB] WIDTH=16 NREG=6 instance");
        apply16(1'b1, F_LD, 6'h3F, 16'hAAAA, 3'd0, 3'd1);
        checkValue("w16 reset o1", 0, q1_16, 16'h0000);
        checkValue("w16 reset flags", 0, {10'd0, flags16}, 16'h0000);
        apply16(1'b0, F_LD, 6'h3F, 16'h1234, 3'd7, 3'd5);
        checkValue("w16 old o2", 1, q2_16, 16'h0000);
        apply16(1'b0, F_INC, 6'h00, 16'h0000, 3'd7, 3'd5);
        checkValue("w16 sel7 o1", 2, q1_16, 16'h0000);
        checkValue("w16 sel5 o2", 2, q2_16, 16'h1234);
        apply16(1'b0, F_INC, 6'h00, 16'h0000, 3'd6, 3'd0);
        checkValue("w16 sel6 o1", 3, q1_16, 16'h0000);
        checkValue("w16 sel0 o2", 3, q2_16, 16'h1234);
        apply16(1'b0, F_CLR, 6'h01, 16'h0000, 3'd0, 3'd1);
        checkValue("w16 pre-clear o1", 4, q1_16, 16'h1234);
        apply16(1'b0, F_DEC, 6'h01, 16'h0000, 3'd0, 3'd1);
        checkValue("w16 dec flags", 5, {10'd0, flags16}, 16'h0001);
        checkValue("w16 dec any", 5, {15'd0, any16}, 16'h0001);
        apply16(1'b0, F_CLR, 6'h00, 16'h0000, 3'd0, 3'd7);
        checkValue("w16 dec result", 6, q1_16, SAT ? 16'h0000 : 16'hFFFF);
        checkValue("w16 sel7 o2", 6, q2_16, 16'h0000);

        checkValue("scoreboard drained", stepNo, 16'(sbq.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
